// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types and constants for the hazard controller
package pipe_pkg;

   localparam int REG_ADDR_W = 5;

   // Pipeline register load enables are active-low.
   localparam logic LD_EN   = 1'b0;
   localparam logic LD_HOLD = 1'b1;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } hz_state_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard comparator
module hazard_detect
   import pipe_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   output logic                  lu_hazard
);

   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign lu_hazard = ex_mem_read && (ex_rd != '0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/bubble sequencing, memory-wait watchdog and stall counter
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 32
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  ex_redirect,
   input  logic                  mem_req,
   input  logic                  mem_ack,
   output logic                  pc_ld,
   output logic                  if_id_ld,
   output logic                  id_ex_ld,
   output logic                  ex_mem_ld,
   output logic                  mem_wb_ld,
   output logic                  if_id_bubble,
   output logic                  id_ex_bubble,
   output logic                  mem_err,
   output logic [CNT_W-1:0]      stall_cnt
);

   localparam int              WD_W   = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

   hz_state_t        state_q, state_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             lu_hazard;
   logic             mem_wait;

   hazard_detect u_hazard_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used),
      .ex_rd       (ex_rd),
      .ex_mem_read (ex_mem_read),
      .lu_hazard   (lu_hazard)
   );

   assign mem_wait = mem_req && !mem_ack;

   always_comb begin
      pc_ld        = LD_EN;
      if_id_ld     = LD_EN;
      id_ex_ld     = LD_EN;
      ex_mem_ld    = LD_EN;
      mem_wb_ld    = LD_EN;
      if_id_bubble = 1'b0;
      id_ex_bubble = 1'b0;
      state_d      = RUN;
      if (mem_wait) begin
         pc_ld     = LD_HOLD;
         if_id_ld  = LD_HOLD;
         id_ex_ld  = LD_HOLD;
         ex_mem_ld = LD_HOLD;
         mem_wb_ld = LD_HOLD;
         state_d   = MEM_WAIT;
      end else if (ex_redirect) begin
         if_id_bubble = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (lu_hazard && (state_q != LU_STALL)) begin
         // The load stays in EX->MEM; only the front end holds while ID/EX takes a NOP.
         pc_ld        = LD_HOLD;
         if_id_ld     = LD_HOLD;
         id_ex_bubble = 1'b1;
         state_d      = LU_STALL;
      end
   end

   always_comb begin
      wd_d      = '0;
      mem_err_d = mem_err_q;
      stall_d   = stall_q;
      if (mem_wait) begin
         wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
         if (wd_d == WD_MAX) begin
            mem_err_d = 1'b1;
         end
      end
      if ((pc_ld == LD_HOLD) && (stall_q != '1)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= RUN;
         wd_q      <= '0;
         mem_err_q <= 1'b0;
         stall_q   <= '0;
      end else begin
         state_q   <= state_d;
         wd_q      <= wd_d;
         mem_err_q <= mem_err_d;
         stall_q   <= stall_d;
      end
   end

   assign mem_err   = mem_err_q;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - vector table, corner sequences and random model check for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
   import pipe_pkg::*;

   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_bubble, id_ex_bubble}
   localparam logic [6:0] P_IDLE = 7'b0000000;
   localparam logic [6:0] P_LU   = 7'b1100001;
   localparam logic [6:0] P_RED  = 7'b0000011;
   localparam logic [6:0] P_WAIT = 7'b1111100;

   logic             clk = 1'b0;
   logic             clr;
   logic [4:0]       id_rs1, id_rs2, ex_rd;
   logic             id_rs1_used, id_rs2_used, ex_mem_read, ex_redirect, mem_req, mem_ack;
   logic             pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld;
   logic             if_id_bubble, id_ex_bubble, mem_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [6:0]       dut_outs;

   int checks = 0;
   int errors = 0;

   logic m_lu_last;
   int   m_run;
   logic m_err;
   int   m_stall;

   typedef struct {
      string      name;
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, mr, redir, req, ack;
      logic [6:0] exp;
   } vec_t;

   vec_t vq[$];

   pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .clr          (clr),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rs1_used  (id_rs1_used),
      .id_rs2_used  (id_rs2_used),
      .ex_rd        (ex_rd),
      .ex_mem_read  (ex_mem_read),
      .ex_redirect  (ex_redirect),
      .mem_req      (mem_req),
      .mem_ack      (mem_ack),
      .pc_ld        (pc_ld),
      .if_id_ld     (if_id_ld),
      .id_ex_ld     (id_ex_ld),
      .ex_mem_ld    (ex_mem_ld),
      .mem_wb_ld    (mem_wb_ld),
      .if_id_bubble (if_id_bubble),
      .id_ex_bubble (id_ex_bubble),
      .mem_err      (mem_err),
      .stall_cnt    (stall_cnt)
   );

   assign dut_outs = {pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld, if_id_bubble, id_ex_bubble};

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic u1, input logic u2, input logic mr,
                          input logic redir, input logic req, input logic ack, input logic [6:0] exp);
      vec_t v;
      v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.u1 = u1; v.u2 = u2;
      v.mr = mr; v.redir = redir; v.req = req; v.ack = ack; v.exp = exp;
      vq.push_back(v);
   endtask

   task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic mr, input logic redir,
                         input logic req, input logic ack);
      id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; id_rs1_used = u1; id_rs2_used = u2;
      ex_mem_read = mr; ex_redirect = redir; mem_req = req; mem_ack = ack;
   endtask

   task automatic set_idle();
      set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic model_reset();
      m_lu_last = 1'b0;
      m_run     = 0;
      m_err     = 1'b0;
      m_stall   = 0;
   endtask

   // Called just after a rising edge; leaves time in the middle of a cycle.
   task automatic pulse_clr();
      clr = 1'b1;
      #1;
      clr = 1'b0;
      model_reset();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] model_outs();
      logic hz;
      hz = ex_mem_read && (ex_rd != 5'd0) &&
           ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
      if (mem_req && !mem_ack) return P_WAIT;
      if (ex_redirect)         return P_RED;
      if (hz && !m_lu_last)    return P_LU;
      return P_IDLE;
   endfunction

   task automatic model_edge(input logic [6:0] o);
      m_lu_last = (o == P_LU);
      if (o == P_WAIT) begin
         m_run++;
         if (m_run >= TIMEOUT) m_err = 1'b1;
      end else begin
         m_run = 0;
      end
      if (o[6] && (m_stall < CNT_MAX)) m_stall++;
   endtask

   initial begin
      logic [6:0] exp;

      clr = 1'b1;
      set_idle();
      model_reset();
      #2;
      chk("reset_outs", 32'(dut_outs), 32'(P_IDLE));
      chk("reset_cnt", 32'(stall_cnt), 0);
      chk("reset_err", 32'(mem_err), 0);
      clr = 1'b0;
      tick();

      add_vec("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, P_IDLE);
      add_vec("lu_rs1",      5, 0, 5, 1, 0, 1, 0, 0, 0, P_LU);
      add_vec("lu_rs2",      0, 7, 7, 0, 1, 1, 0, 0, 0, P_LU);
      add_vec("x0_dest",     0, 0, 0, 1, 1, 1, 0, 0, 0, P_IDLE);
      add_vec("rs2_unused",  0, 5, 5, 0, 0, 1, 0, 0, 0, P_IDLE);
      add_vec("not_load",    5, 0, 5, 1, 0, 0, 0, 0, 0, P_IDLE);
      add_vec("redir_lu",    5, 0, 5, 1, 0, 1, 1, 0, 0, P_RED);
      add_vec("redir",       0, 0, 0, 0, 0, 0, 1, 0, 0, P_RED);
      add_vec("wait_all",    5, 0, 5, 1, 0, 1, 1, 1, 0, P_WAIT);
      add_vec("req_ack",     0, 0, 0, 0, 0, 0, 0, 1, 1, P_IDLE);
      add_vec("ack_only",    0, 0, 0, 0, 0, 0, 0, 0, 1, P_IDLE);
      add_vec("req_ack_lu",  9, 9, 9, 0, 1, 1, 0, 1, 1, P_LU);

      foreach (vq[i]) begin
         pulse_clr();
         set_in(vq[i].rs1, vq[i].rs2, vq[i].rd, vq[i].u1, vq[i].u2, vq[i].mr,
                vq[i].redir, vq[i].req, vq[i].ack);
         #2;
         chk({"vec_", vq[i].name}, 32'(dut_outs), 32'(vq[i].exp));
         tick();
         chk({"vec_cnt_", vq[i].name}, 32'(stall_cnt), vq[i].exp[6] ? 1 : 0);
         set_idle();
      end

      // Load-use held for two cycles: exactly one bubble.
      pulse_clr();
      set_in(5, 0, 5, 1, 0, 1, 0, 0, 0);
      #2;
      chk("lu_first", 32'(dut_outs), 32'(P_LU));
      tick();
      chk("lu_second", 32'(dut_outs), 32'(P_IDLE));
      chk("lu_cnt", 32'(stall_cnt), 1);
      tick();
      chk("lu_cnt_after", 32'(stall_cnt), 1);

      // Three-cycle memory wait, then ack.
      pulse_clr();
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int k = 1; k <= 3; k++) begin
         #2;
         chk($sformatf("mw_hold%0d", k), 32'(dut_outs), 32'(P_WAIT));
         tick();
      end
      mem_ack = 1'b1;
      #2;
      chk("mw_ack_outs", 32'(dut_outs), 32'(P_IDLE));
      tick();
      chk("mw_cnt", 32'(stall_cnt), 3);
      chk("mw_err", 32'(mem_err), 0);

      // Redirect held through a wait takes effect on the ack cycle.
      pulse_clr();
      set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
      tick();
      mem_ack = 1'b1;
      #2;
      chk("mw_redir_ack", 32'(dut_outs), 32'(P_RED));
      set_idle();
      tick();

      // Watchdog: six stalled cycles with TIMEOUT=4.
      pulse_clr();
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("wd_err%0d", k), 32'(mem_err), (k >= TIMEOUT) ? 1 : 0);
      end
      mem_ack = 1'b1;
      tick();
      chk("wd_err_after_ack", 32'(mem_err), 1);
      set_idle();
      tick();
      chk("wd_err_sticky", 32'(mem_err), 1);
      pulse_clr();
      chk("wd_err_clr", 32'(mem_err), 0);
      chk("wd_cnt_clr", 32'(stall_cnt), 0);

      // Reset during cycle 2 of a wait must also clear the watchdog count.
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      clr = 1'b1;
      mem_req = 1'b0;
      #1;
      chk("rst_wait_outs", 32'(dut_outs), 32'(P_IDLE));
      chk("rst_wait_cnt", 32'(stall_cnt), 0);
      chk("rst_wait_err", 32'(mem_err), 0);
      clr = 1'b0;
      mem_req = 1'b1;
      for (int k = 1; k <= TIMEOUT; k++) begin
         tick();
         chk($sformatf("rst_wd%0d", k), 32'(mem_err), (k == TIMEOUT) ? 1 : 0);
      end
      set_idle();

      // Reset during LU_STALL: state returns to RUN so the hazard stalls again.
      pulse_clr();
      set_in(5, 0, 5, 1, 0, 1, 0, 0, 0);
      tick();
      #1;
      chk("rst_lu_before", 32'(dut_outs), 32'(P_IDLE));
      clr = 1'b1;
      #1;
      chk("rst_lu_outs", 32'(dut_outs), 32'(P_LU));
      chk("rst_lu_cnt", 32'(stall_cnt), 0);
      clr = 1'b0;
      set_idle();
      tick();

      // Randomized run against the behavioural model.
      pulse_clr();
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 199) == 0) pulse_clr();
         id_rs1      = 5'($urandom_range(0, 3));
         id_rs2      = 5'($urandom_range(0, 3));
         ex_rd       = 5'($urandom_range(0, 3));
         id_rs1_used = 1'($urandom_range(0, 1));
         id_rs2_used = 1'($urandom_range(0, 1));
         ex_mem_read = 1'($urandom_range(0, 1));
         ex_redirect = ($urandom_range(0, 5) == 0);
         mem_req     = ($urandom_range(0, 2) != 0);
         mem_ack     = ($urandom_range(0, 3) == 0);
         #1;
         exp = model_outs();
         chk("rand_outs", 32'(dut_outs), 32'(exp));
         tick();
         model_edge(exp);
         chk("rand_cnt", 32'(stall_cnt), 32'(m_stall));
         chk("rand_err", 32'(mem_err), 32'(m_err));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
